// File: rtl/ram_responder_pkg.sv
// Shared types and constants for the RAM-side word protocol endpoint.
// The state encoding is fixed so that waveform viewers and other RTL agree on it.
package ram_responder_pkg;

    localparam int ADDR_SIZE_DEFAULT     = 13;
    localparam int WORD_SIZE_DEFAULT     = 16;
    localparam int READ_LATENCY_DEFAULT  = 2;
    localparam int REQ_DEPTH_LOG_DEFAULT = 3;

    // Request entries are packed as {rnw, addr, wdata}
    function automatic int req_width(input int addr_size, input int word_size);
        return word_size + addr_size + 1;
    endfunction

    localparam int REQ_W = req_width(ADDR_SIZE_DEFAULT, WORD_SIZE_DEFAULT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DATA = 2'd2,
        ACK  = 2'd3
    } state_t;

endpackage

// File: rtl/ram_responder_sync_fifo.sv
// Single-clock FIFO used as the request queue; dout always shows the head entry.
// Pushes into a full queue are ignored, judged on occupancy before any same-cycle pop.
module sync_fifo #(
    parameter int WIDTH     = 8,
    parameter int DEPTH_LOG = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int DEPTH = 1 << DEPTH_LOG;
    localparam logic [DEPTH_LOG:0] FULL_COUNT = {1'b1, {DEPTH_LOG{1'b0}}};

    logic [WIDTH-1:0]     entries [DEPTH];
    logic [DEPTH_LOG-1:0] wr_ptr;
    logic [DEPTH_LOG-1:0] rd_ptr;
    logic [DEPTH_LOG:0]   count;
    logic                 do_push;
    logic                 do_pop;

    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = entries[rd_ptr];

    // Storage carries no reset so it can map onto plain RAM cells
    always_ff @(posedge clk) begin
        if (do_push && !reset) begin
            entries[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ram_responder.sv
// RAM-side endpoint of the cache<->RAM word protocol: queues requests, owns the storage
// array, and answers reads with registered data followed by a one-cycle ack.
module ram_responder
    import ram_responder_pkg::*;
#(
    parameter int ADDR_SIZE     = 13,
    parameter int WORD_SIZE     = 16,
    parameter int READ_LATENCY  = 2,
    parameter int REQ_DEPTH_LOG = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [ADDR_SIZE-1:0] ram_addr,
    input  logic                 ram_avalid,
    input  logic                 ram_rnw,
    input  logic [WORD_SIZE-1:0] ram_wdata,
    output logic [WORD_SIZE-1:0] ram_rdata,
    output logic                 ram_ack,
    output logic                 busy,
    output logic                 overflow
);

    localparam int ENTRY_W   = req_width(ADDR_SIZE, WORD_SIZE);
    localparam int MEM_DEPTH = 1 << ADDR_SIZE;
    localparam int CNT_W     = (READ_LATENCY > 1) ? $clog2(READ_LATENCY + 1) : 1;

    logic [WORD_SIZE-1:0] mem [MEM_DEPTH];

    logic [ENTRY_W-1:0]   req_in;
    logic [ENTRY_W-1:0]   req_head;
    logic                 q_full;
    logic                 q_empty;
    logic                 q_pop;
    logic                 head_rnw;
    logic [ADDR_SIZE-1:0] head_addr;
    logic [WORD_SIZE-1:0] head_wdata;

    state_t               state;
    logic [CNT_W-1:0]     wait_cnt;
    logic [ADDR_SIZE-1:0] rd_addr;
    logic [ADDR_SIZE-1:0] fetch_addr;

    assign req_in                              = {ram_rnw, ram_addr, ram_wdata};
    assign {head_rnw, head_addr, head_wdata}   = req_head;
    assign q_pop                               = (state == IDLE) && !q_empty;
    assign busy                                = !q_empty || (state != IDLE);

    // With zero latency the read is fetched straight from the queue head
    assign fetch_addr = (READ_LATENCY == 0) ? head_addr : rd_addr;

    sync_fifo #(
        .WIDTH     (ENTRY_W),
        .DEPTH_LOG (REQ_DEPTH_LOG)
    ) u_req_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (ram_avalid),
        .pop   (q_pop),
        .din   (req_in),
        .dout  (req_head),
        .full  (q_full),
        .empty (q_empty)
    );

    // Contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (!reset && q_pop && !head_rnw) begin
            mem[head_addr] <= head_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            rd_addr   <= '0;
            ram_rdata <= '0;
            ram_ack   <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            ram_ack <= 1'b0;
            if (ram_avalid && q_full) begin
                overflow <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (!q_empty && head_rnw) begin
                        rd_addr  <= head_addr;
                        wait_cnt <= CNT_W'(READ_LATENCY);
                        if (READ_LATENCY == 0) begin
                            ram_rdata <= mem[fetch_addr];
                            state     <= DATA;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    wait_cnt <= wait_cnt - 1'b1;
                    if (wait_cnt == CNT_W'(1)) begin
                        ram_rdata <= mem[fetch_addr];
                        state     <= DATA;
                    end
                end
                // Data is already stable here; ack follows so the receiver's delayed sample lines up
                DATA: begin
                    ram_ack <= 1'b1;
                    state   <= ACK;
                end
                ACK: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
